// File: rtl/usb_trans_ctrl_pkg.sv
// rtl/usb_trans_ctrl_pkg.sv - shared PID and transaction-state types for the USB device transaction sequencer
package usb_trans_ctrl_pkg;

    // USB packet identifiers (4-bit PID, check field handled by the receiver)
    typedef enum logic [3:0] {
        PID_RESERVED = 4'h0,
        PID_OUT      = 4'h1,
        PID_ACK      = 4'h2,
        PID_DATA0    = 4'h3,
        PID_PING     = 4'h4,
        PID_SOF      = 4'h5,
        PID_NYET     = 4'h6,
        PID_DATA2    = 4'h7,
        PID_SPLIT    = 4'h8,
        PID_IN       = 4'h9,
        PID_NAK      = 4'hA,
        PID_DATA1    = 4'hB,
        PID_PRE      = 4'hC,
        PID_SETUP    = 4'hD,
        PID_STALL    = 4'hE,
        PID_MDATA    = 4'hF
    } pid_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DATA,
        ST_RX_DATA,
        ST_TX_WAIT,
        ST_WAIT_ACK
    } trans_state_t;

    localparam int BTO_CYCLES_DEFAULT = 72;

    // DATA0/DATA1 are the only data PIDs a full-speed device sequences
    function automatic logic pid_is_data01(input pid_t p);
        return (p == PID_DATA0) || (p == PID_DATA1);
    endfunction

endpackage

// File: rtl/usb_bto_timer.sv
// rtl/usb_bto_timer.sv - bus turnaround time-out counter (load, decrement, expire)
module usb_bto_timer #(
    parameter int CYCLES = 72
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic run_i,
    output logic expire_o
);

    localparam int W = $clog2(CYCLES + 1);
    localparam logic [W-1:0] LOAD_VAL = W'(CYCLES);
    localparam logic [W-1:0] ONE      = W'(1);

    logic [W-1:0] cnt_q, cnt_d;

    // expiry is flagged on the cycle whose decrement reaches zero
    assign expire_o = run_i && (cnt_q == ONE);

    // reload on entry to a waiting state, otherwise count down while running
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (run_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    // counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/usb_trans_ctrl.sv
// rtl/usb_trans_ctrl.sv - device-side USB transaction sequencer between packet receiver and transmitter
module usb_trans_ctrl
    import usb_trans_ctrl_pkg::*;
#(
    parameter int NUM_EP     = 4,
    parameter int BTO_CYCLES = BTO_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        dev_addr,
    input  logic              tok_valid,
    input  pid_t              tok_pid,
    input  logic [6:0]        tok_addr,
    input  logic [3:0]        tok_endp,
    input  logic              tok_crc5_ok,
    input  logic              rx_pid_valid,
    input  pid_t              rx_pid,
    input  logic              rx_data_done,
    input  logic              rx_crc16_ok,
    input  logic              rx_pid_err,
    input  logic              usb_reset,
    input  logic [NUM_EP-1:0] ep_stall,
    input  logic [NUM_EP-1:0] ep_in_ready,
    input  logic [NUM_EP-1:0] ep_out_ready,
    input  logic              tx_busy,
    input  logic              tx_done,
    output logic              tx_start,
    output pid_t              tx_pid,
    output logic [3:0]        ep_sel,
    output logic              out_commit,
    output logic              out_discard,
    output logic              stat_token_done,
    output logic              stat_stall,
    output logic              stat_bto,
    output logic              stat_crc5,
    output logic              stat_crc16,
    output logic              stat_pid,
    output logic              stat_reset
);

    localparam logic [4:0] NUM_EP_L = 5'(NUM_EP);

    trans_state_t      state_q, state_d;
    logic [3:0]        ep_q, ep_d;
    logic [NUM_EP-1:0] tog_q, tog_d;
    pid_t              txpid_q, txpid_d, req_pid;
    logic              req_tx, kill;
    logic              pend_q, pend_d;
    logic              is_setup_q, is_setup_d;
    logic              data1_q, data1_d;
    logic              usb_reset_q;
    logic              start_q, start_d, commit_q, commit_d, discard_q, discard_d;
    logic              done_q, done_d, stall_q, stall_d, bto_q, bto_d;
    logic              crc5_q, crc5_d, crc16_q, crc16_d, pid_q, pid_d, rst_ev_q, rst_ev_d;
    logic [3:0]        sel_idx;
    logic [NUM_EP-1:0] sel_mask;
    logic              sel_stall, sel_in_rdy, sel_out_rdy, sel_tog;
    logic              tok_hit, bto_load, bto_run, bto_expire;

    usb_bto_timer #(.CYCLES(BTO_CYCLES)) u_bto (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (bto_load),
        .run_i    (bto_run),
        .expire_o (bto_expire)
    );

    assign bto_run  = (state_q == ST_WAIT_DATA) || (state_q == ST_WAIT_ACK);
    assign bto_load = ((state_d == ST_WAIT_DATA) || (state_d == ST_WAIT_ACK)) && (state_d != state_q);

    assign tok_hit = tok_valid && tok_crc5_ok && (tok_addr == dev_addr) &&
                     ({1'b0, tok_endp} < NUM_EP_L) &&
                     ((tok_pid == PID_IN) || (tok_pid == PID_OUT) || (tok_pid == PID_SETUP));

    // per-endpoint view: the incoming token's endpoint in IDLE, the latched one afterwards
    always_comb begin
        sel_idx     = (state_q == ST_IDLE) ? tok_endp : ep_q;
        sel_mask    = '0;
        sel_stall   = 1'b0;
        sel_in_rdy  = 1'b0;
        sel_out_rdy = 1'b0;
        sel_tog     = 1'b0;
        for (int i = 0; i < NUM_EP; i++) begin
            if (sel_idx == 4'(i)) begin
                sel_mask[i] = 1'b1;
                sel_stall   = ep_stall[i];
                sel_in_rdy  = ep_in_ready[i];
                sel_out_rdy = ep_out_ready[i];
                sel_tog     = tog_q[i];
            end
        end
    end

    // next-state, response selection and status pulses
    always_comb begin
        state_d    = state_q;
        ep_d       = ep_q;
        tog_d      = tog_q;
        txpid_d    = txpid_q;
        is_setup_d = is_setup_q;
        data1_d    = data1_q;
        req_tx     = 1'b0;
        req_pid    = PID_RESERVED;
        kill       = 1'b0;
        pend_d     = 1'b0;
        start_d    = 1'b0;
        commit_d   = 1'b0;
        discard_d  = 1'b0;
        done_d     = 1'b0;
        stall_d    = 1'b0;
        bto_d      = 1'b0;
        crc5_d     = 1'b0;
        crc16_d    = 1'b0;
        pid_d      = 1'b0;
        rst_ev_d   = usb_reset && !usb_reset_q;

        if (usb_reset) begin
            // bus reset overrides everything and drops any queued response
            state_d = ST_IDLE;
            tog_d   = '0;
            txpid_d = PID_RESERVED;
        end else begin
            if ((state_q != ST_IDLE) && rx_pid_err) begin
                pid_d     = 1'b1;
                discard_d = (state_q == ST_RX_DATA);
                state_d   = ST_IDLE;
                kill      = 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (tok_valid && !tok_crc5_ok) begin
                            crc5_d = 1'b1;
                        end else if (tok_hit) begin
                            ep_d       = tok_endp;
                            is_setup_d = (tok_pid == PID_SETUP);
                            if (tok_pid == PID_IN) begin
                                req_tx  = 1'b1;
                                state_d = ST_TX_WAIT;
                                if (sel_stall) begin
                                    req_pid = PID_STALL;
                                    stall_d = 1'b1;
                                end else if (!sel_in_rdy) begin
                                    req_pid = PID_NAK;
                                end else begin
                                    req_pid = sel_tog ? PID_DATA1 : PID_DATA0;
                                end
                            end else begin
                                state_d = ST_WAIT_DATA;
                            end
                        end
                    end
                    ST_WAIT_DATA: begin
                        if (rx_pid_valid) begin
                            if (pid_is_data01(rx_pid)) begin
                                state_d = ST_RX_DATA;
                                data1_d = (rx_pid == PID_DATA1);
                            end else begin
                                pid_d   = 1'b1;
                                state_d = ST_IDLE;
                            end
                        end else if (bto_expire) begin
                            bto_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                    ST_RX_DATA: begin
                        if (rx_data_done) begin
                            if (!rx_crc16_ok) begin
                                discard_d = 1'b1;
                                crc16_d   = 1'b1;
                                state_d   = ST_IDLE;
                            end else begin
                                req_tx  = 1'b1;
                                state_d = ST_TX_WAIT;
                                if (is_setup_q) begin
                                    // SETUP is always accepted and restarts the data sequence at DATA1
                                    req_pid  = PID_ACK;
                                    commit_d = 1'b1;
                                    tog_d    = tog_q | sel_mask;
                                end else if (sel_stall) begin
                                    req_pid   = PID_STALL;
                                    discard_d = 1'b1;
                                    stall_d   = 1'b1;
                                end else if (!sel_out_rdy) begin
                                    req_pid   = PID_NAK;
                                    discard_d = 1'b1;
                                end else if (data1_q != sel_tog) begin
                                    // host missed our ACK and resent: acknowledge, keep nothing
                                    req_pid   = PID_ACK;
                                    discard_d = 1'b1;
                                end else begin
                                    req_pid  = PID_ACK;
                                    commit_d = 1'b1;
                                    tog_d    = tog_q ^ sel_mask;
                                end
                            end
                        end
                    end
                    ST_TX_WAIT: begin
                        if (tx_done && !pend_q) begin
                            if (pid_is_data01(txpid_q)) begin
                                state_d = ST_WAIT_ACK;
                            end else begin
                                done_d  = 1'b1;
                                state_d = ST_IDLE;
                            end
                        end
                    end
                    ST_WAIT_ACK: begin
                        if (rx_pid_valid) begin
                            state_d = ST_IDLE;
                            if (rx_pid == PID_ACK) begin
                                tog_d  = tog_q ^ sel_mask;
                                done_d = 1'b1;
                            end
                        end else if (bto_expire) begin
                            bto_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end

            if (req_tx) begin
                txpid_d = req_pid;
            end
            // launch now if the transmitter is free, otherwise keep the request pending
            if (req_tx || (pend_q && !kill)) begin
                if (tx_busy) begin
                    pend_d = 1'b1;
                end else begin
                    start_d = 1'b1;
                end
            end
        end
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ep_q        <= '0;
            tog_q       <= '0;
            txpid_q     <= PID_RESERVED;
            pend_q      <= 1'b0;
            is_setup_q  <= 1'b0;
            data1_q     <= 1'b0;
            usb_reset_q <= 1'b0;
            start_q     <= 1'b0;
            commit_q    <= 1'b0;
            discard_q   <= 1'b0;
            done_q      <= 1'b0;
            stall_q     <= 1'b0;
            bto_q       <= 1'b0;
            crc5_q      <= 1'b0;
            crc16_q     <= 1'b0;
            pid_q       <= 1'b0;
            rst_ev_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ep_q        <= ep_d;
            tog_q       <= tog_d;
            txpid_q     <= txpid_d;
            pend_q      <= pend_d;
            is_setup_q  <= is_setup_d;
            data1_q     <= data1_d;
            usb_reset_q <= usb_reset;
            start_q     <= start_d;
            commit_q    <= commit_d;
            discard_q   <= discard_d;
            done_q      <= done_d;
            stall_q     <= stall_d;
            bto_q       <= bto_d;
            crc5_q      <= crc5_d;
            crc16_q     <= crc16_d;
            pid_q       <= pid_d;
            rst_ev_q    <= rst_ev_d;
        end
    end

    assign tx_start        = start_q;
    assign tx_pid          = txpid_q;
    assign ep_sel          = ep_q;
    assign out_commit      = commit_q;
    assign out_discard     = discard_q;
    assign stat_token_done = done_q;
    assign stat_stall      = stall_q;
    assign stat_bto        = bto_q;
    assign stat_crc5       = crc5_q;
    assign stat_crc16      = crc16_q;
    assign stat_pid        = pid_q;
    assign stat_reset      = rst_ev_q;

endmodule
